relu_stream_ctrl: RTL
=====================

# relu_stream_ctrl

Sequencer that feeds one layer's convolution results through a registered, lane-parallel ReLU stage under valid/ready flow control. Accepts a per-layer job (beat count, ReLU enable), counts beats, flags the last beat, counts negative lanes clamped to zero for sparsity statistics, and pulses done when the layer is fully drained. Sits between the convolution/accumulation array output and the pooling/write-back buffer in the 16-bit FC/conv datapath.

## Interface
- FW, 16, fixed-point word width (two's complement)
- LANES, 8, words per beat
- LW, 16, width of beat-count field
- ZW, 24, width of zero-lane statistic counter
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  job start; honoured only when cfg_ready_o=1
- len_i  in  LW  beats in job; sampled with start_i
- relu_en_i  in  1  1=apply ReLU, 0=pass-through (final FC layer); sampled with start_i
- cfg_ready_o  out  1  high in IDLE only
- in_valid_i  in  1  input beat valid
- in_data_i  in  LANES*FW  lane k at [(k+1)*FW-1 : k*FW]
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
- out_valid_o  out  1  output beat valid
- out_data_o  out  LANES*FW  processed beat, same lane packing
- out_last_o  out  1  high with final beat of job
- out_ready_i  in  1  downstream accept
- done_o  out  1  one-cycle pulse at job completion
- zero_cnt_o  out  ZW  lanes clamped this job, saturating

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cfg_ready_o=1, in_ready_o=0. On start_i: latch len_i, relu_en_i; clear beat counter and zero_cnt_o. If len_i=0 -> stay IDLE, done_o=1 next cycle. Else -> RUN.
- RUN: in_ready_o = ~out_valid_o | out_ready_i (single output register, full throughput). On accept: out_data_o <= per-lane f(x), out_valid_o<=1, beat counter++, out_last_o <= (counter+1 == len). Accept of beat len -> DRAIN.
- f(x): relu_en=1 and lane sign bit (bit FW-1)=1 -> all-zero; else x unchanged. 0x8000 clamps to 0; 0x0000 passes, not counted.
- zero_cnt_o += number of clamped lanes in each accepted beat (0..LANES); saturates at 2^ZW-1, never wraps. Stays 0 when relu_en=0. Holds value after job until next start_i.
- DRAIN: in_ready_o=0. When out_valid_o & out_ready_i: out_valid_o<=0, out_last_o<=0, done_o=1 for one cycle, -> IDLE.
- out_valid_o drops after handshake if no new beat accepted the same cycle; data/last held stable while out_valid_o & ~out_ready_i.
- start_i outside IDLE ignored. in_valid_i in IDLE/DRAIN ignored (not accepted).

## Timing
- Reset (async assert, sync release): state=IDLE, cfg_ready_o=1, in_ready_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, done_o=0, zero_cnt_o=0, beat counter=0.
- Reset mid-job: all of the above immediately; in-flight beat discarded, no done_o.
- Latency: input accept at cycle N -> out_valid_o at N+1.
- Throughput: 1 beat/cycle with out_ready_i held high.
- done_o asserted the cycle after last output handshake; cfg_ready_o high that same cycle; start_i may be accepted then.
- Simultaneous in accept and out handshake in RUN: register reloads, out_valid_o stays 1.
- len_i=0: start at N -> done_o at N+1, no output beats.

## Test plan
- Basic: len=4, relu_en=1, lanes {+5,-3,0,0x8000,...}, out_ready_i=1 -> outputs {5,0,0,0,...} one cycle after each accept, out_last_o on beat 4 only, done_o one cycle after beat 4 handshake, zero_cnt_o=count of negative lanes (e.g., 8 for 4 beats × 2 negatives).
- Bypass: relu_en=0, negatives in all lanes, len=2 -> data unchanged, zero_cnt_o=0.
- Backpressure: len=3, out_ready_i low for 5 cycles after first beat -> in_ready_o=0, out_data_o stable, no beat lost/duplicated, order preserved.
- Zero-length and ignored start: len=0 -> done_o next cycle, no out_valid_o; start_i during RUN -> len/counter unchanged.
- Saturation: ZW=4 build, len=3, all 8 lanes negative -> zero_cnt_o=15, not 8.
- Reset mid-job: assert rst_i after 2 of 5 beats -> all outputs reset values same cycle, no done_o; new job len=1 runs correctly after release.

Source files
------------

// File: rtl/relu_stream_ctrl_if.sv
// Stream/config bundle for relu_stream_ctrl: job setup, input beats, output beats, status.
// The master side is the job/producer/consumer environment; slave is the controller.
interface relu_stream_ctrl_if #(
    parameter int FW    = 16,
    parameter int LANES = 8,
    parameter int LW    = 16,
    parameter int ZW    = 24
);
    logic                  start_i;
    logic [LW-1:0]         len_i;
    logic                  relu_en_i;
    logic                  cfg_ready_o;
    logic                  in_valid_i;
    logic [LANES*FW-1:0]   in_data_i;
    logic                  in_ready_o;
    logic                  out_valid_o;
    logic [LANES*FW-1:0]   out_data_o;
    logic                  out_last_o;
    logic                  out_ready_i;
    logic                  done_o;
    logic [ZW-1:0]         zero_cnt_o;

    modport master (
        output start_i, len_i, relu_en_i, in_valid_i, in_data_i, out_ready_i,
        input  cfg_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
               done_o, zero_cnt_o
    );

    modport slave (
        input  start_i, len_i, relu_en_i, in_valid_i, in_data_i, out_ready_i,
        output cfg_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
               done_o, zero_cnt_o
    );
endinterface

// File: rtl/relu_stream_ctrl.sv
// Per-layer ReLU sequencer: lane-parallel clamp into a single output register with
// valid/ready flow control, beat counting, last/done generation and sparsity statistics.

module relu_lane #(
    parameter int FW = 16
) (
    input  logic [FW-1:0] x,
    input  logic          en,
    output logic [FW-1:0] y,
    output logic          clamp
);
    assign clamp = en & x[FW-1];
    assign y     = clamp ? '0 : x;
endmodule

module relu_stream_ctrl #(
    parameter int FW    = 16,
    parameter int LANES = 8,
    parameter int LW    = 16,
    parameter int ZW    = 24
) (
    input  logic                clk_i,
    input  logic                rst_i,
    relu_stream_ctrl_if.slave   bus
);
    localparam int CW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state, state_nx;
    logic [LW-1:0]             len_q, beat_cnt;
    logic                      relu_en_q;
    logic [LANES-1:0][FW-1:0]  in_lanes, res_lanes, out_q;
    logic [LANES-1:0]          clamp;
    logic [CW-1:0]             nclamp;
    logic [ZW:0]               zsum;
    logic [ZW-1:0]             zero_cnt_q;
    logic                      out_valid_q, out_last_q, done_q;
    logic                      in_ready, accept, out_hs, cfg_go, last_acc;

    assign in_lanes = bus.in_data_i;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        relu_lane #(.FW(FW)) u_lane (
            .x     (in_lanes[k]),
            .en    (relu_en_q),
            .y     (res_lanes[k]),
            .clamp (clamp[k])
        );
    end

    // One output register: a new beat may enter whenever the held one leaves this cycle.
    assign in_ready = (state == RUN) & (~out_valid_q | bus.out_ready_i);
    assign accept   = bus.in_valid_i & in_ready;
    assign out_hs   = out_valid_q & bus.out_ready_i;
    assign cfg_go   = (state == IDLE) & bus.start_i;
    assign last_acc = accept & ((beat_cnt + LW'(1)) == len_q);

    always_comb begin
        nclamp = '0;
        for (int k = 0; k < LANES; k++) nclamp = nclamp + CW'(clamp[k]);
    end

    // One extra bit catches overflow so the statistic saturates instead of wrapping.
    assign zsum = {1'b0, zero_cnt_q} + (ZW+1)'(nclamp);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start_i && (bus.len_i != '0)) state_nx = RUN;
            RUN:     if (last_acc) state_nx = DRAIN;
            DRAIN:   if (out_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q       <= '0;
            relu_en_q   <= 1'b0;
            beat_cnt    <= '0;
            zero_cnt_q  <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (cfg_go && (bus.len_i == '0)) || ((state == DRAIN) && out_hs);
            if (cfg_go) begin
                len_q      <= bus.len_i;
                relu_en_q  <= bus.relu_en_i;
                beat_cnt   <= '0;
                zero_cnt_q <= '0;
            end
            if (accept) begin
                out_q       <= res_lanes;
                out_valid_q <= 1'b1;
                out_last_q  <= last_acc;
                beat_cnt    <= beat_cnt + LW'(1);
                zero_cnt_q  <= zsum[ZW] ? '1 : zsum[ZW-1:0];
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready_o = (state == IDLE);
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.done_o      = done_q;
    assign bus.zero_cnt_o  = zero_cnt_q;
endmodule
